// File: rtl/acumulador_sat_if.sv
// Request/result bundle for the saturating multi-channel accumulator.
// The master side issues requests and consumes results; the slave side is
// the accumulator itself.
interface acumulador_sat_if #(
  parameter int ANCHO   = 16,
  parameter int CANALES = 4
);

  localparam int CW = $clog2(CANALES);

  // Request channel
  logic                 in_valid;
  logic                 in_ready;
  logic [CW-1:0]        canal;
  logic [1:0]           modo;
  logic [ANCHO-1:0]     operando;

  // Result channel
  logic                 out_valid;
  logic                 out_ready;
  logic [CW-1:0]        out_canal;
  logic [ANCHO-1:0]     resultado;
  logic                 sat_pos;
  logic                 sat_neg;

  // Per-channel sticky saturation status
  logic [CANALES-1:0]   ovf_sticky;
  logic [CANALES-1:0]   clr_ovf;

  modport master (
    output in_valid, canal, modo, operando, out_ready, clr_ovf,
    input  in_ready, out_valid, out_canal, resultado, sat_pos, sat_neg,
           ovf_sticky
  );

  modport slave (
    input  in_valid, canal, modo, operando, out_ready, clr_ovf,
    output in_ready, out_valid, out_canal, resultado, sat_pos, sat_neg,
           ovf_sticky
  );

endinterface

// File: rtl/acumulador_sat.sv
// Multi-channel signed accumulator with saturation.
// Two pipeline stages: S1 captures an accepted request, S2 performs the
// add/sub/load/clear against the channel accumulator, writes the new value
// back and presents it on the result channel in the same edge. Because the
// accumulator is read from its register when the request sits in S1, two
// back-to-back requests to the same channel always see each other's result.
// A result that is not taken by the consumer freezes S2, S1 and all
// accumulators until it is.
module acumulador_sat #(
  parameter int ANCHO   = 16,
  parameter int CANALES = 4
) (
  input  logic               clk,
  input  logic               reset,
  acumulador_sat_if.slave    bus
);

  localparam int CW = $clog2(CANALES);

  // Most positive and most negative representable values.
  localparam logic signed [ANCHO-1:0] MAX_VAL = {1'b0, {(ANCHO-1){1'b1}}};
  localparam logic signed [ANCHO-1:0] MIN_VAL = {1'b1, {(ANCHO-1){1'b0}}};

  typedef enum logic [1:0] {
    MODO_ADD   = 2'b00,
    MODO_SUB   = 2'b01,
    MODO_LOAD  = 2'b10,
    MODO_CLEAR = 2'b11
  } modo_e;

  // Stage 1 request register
  logic                     r_s1Valid;
  logic [CW-1:0]            r_s1Canal;
  modo_e                    r_s1Modo;
  logic signed [ANCHO-1:0]  r_s1Op;

  // Stage 2 output registers
  logic                     r_outValid;
  logic [CW-1:0]            r_outCanal;
  logic signed [ANCHO-1:0]  r_resultado;
  logic                     r_satPos;
  logic                     r_satNeg;

  // Channel state
  logic signed [ANCHO-1:0]  r_acc [CANALES];
  logic [CANALES-1:0]       r_ovf;

  // Handshake / control
  logic                     w_stall;
  logic                     w_inReady;
  logic                     w_accept;
  logic                     w_s2Load;

  // Datapath
  logic signed [ANCHO-1:0]  w_accOld;
  logic signed [ANCHO:0]    w_accExt;
  logic signed [ANCHO:0]    w_opExt;
  logic signed [ANCHO:0]    w_full;
  logic signed [ANCHO-1:0]  w_newVal;
  logic                     w_newSatPos;
  logic                     w_newSatNeg;
  logic [CANALES-1:0]       w_setMask;

  // Flow control: a pending result that the consumer refuses freezes the
  // pipeline; S1 can still fill while the pipeline is frozen if it was empty.
  always_comb begin
    w_stall   = r_outValid & ~bus.out_ready;
    w_inReady = reset & (~r_s1Valid | ~r_outValid | bus.out_ready);
    w_accept  = bus.in_valid & w_inReady;
    w_s2Load  = r_s1Valid & ~w_stall;
  end

  // Operands widened by one bit so add/sub (including negating MIN) never wrap.
  always_comb begin
    w_accOld = r_acc[r_s1Canal];
    w_accExt = {w_accOld[ANCHO-1], w_accOld};
    w_opExt  = {r_s1Op[ANCHO-1], r_s1Op};
  end

  // Compute the new accumulator value and clamp it; the two top bits of the
  // widened sum disagree exactly when the true result leaves the signed range.
  always_comb begin
    w_full      = '0;
    w_newVal    = '0;
    w_newSatPos = 1'b0;
    w_newSatNeg = 1'b0;
    case (r_s1Modo)
      MODO_ADD, MODO_SUB: begin
        if (r_s1Modo == MODO_ADD) begin
          w_full = w_accExt + w_opExt;
        end else begin
          w_full = w_accExt - w_opExt;
        end
        w_newSatPos = (w_full[ANCHO:ANCHO-1] == 2'b01);
        w_newSatNeg = (w_full[ANCHO:ANCHO-1] == 2'b10);
        if (w_newSatPos) begin
          w_newVal = MAX_VAL;
        end else if (w_newSatNeg) begin
          w_newVal = MIN_VAL;
        end else begin
          w_newVal = w_full[ANCHO-1:0];
        end
      end
      MODO_LOAD: begin
        w_newVal = r_s1Op;
      end
      default: begin
        w_newVal = '0;
      end
    endcase
  end

  // One-hot mark of the channel whose written result was clamped this edge.
  always_comb begin
    w_setMask = '0;
    if (w_s2Load && (w_newSatPos || w_newSatNeg)) begin
      w_setMask[r_s1Canal] = 1'b1;
    end
  end

  // S1: capture an accepted request, or drain once it has moved into S2.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1Valid <= 1'b0;
      r_s1Canal <= '0;
      r_s1Modo  <= MODO_ADD;
      r_s1Op    <= '0;
    end else if (w_accept) begin
      r_s1Valid <= 1'b1;
      r_s1Canal <= bus.canal;
      r_s1Modo  <= modo_e'(bus.modo);
      r_s1Op    <= bus.operando;
    end else if (w_s2Load) begin
      r_s1Valid <= 1'b0;
    end
  end

  // S2: load the output registers from S1 unless the consumer is stalling.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_outValid  <= 1'b0;
      r_outCanal  <= '0;
      r_resultado <= '0;
      r_satPos    <= 1'b0;
      r_satNeg    <= 1'b0;
    end else if (!w_stall) begin
      r_outValid <= r_s1Valid;
      if (r_s1Valid) begin
        r_outCanal  <= r_s1Canal;
        r_resultado <= w_newVal;
        r_satPos    <= w_newSatPos;
        r_satNeg    <= w_newSatNeg;
      end
    end
  end

  // Accumulator bank: written with exactly the value presented on the output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < CANALES; i++) begin
        r_acc[i] <= '0;
      end
    end else if (w_s2Load) begin
      r_acc[r_s1Canal] <= w_newVal;
    end
  end

  // Sticky saturation flags: a new saturation beats a same-edge clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ovf <= '0;
    end else begin
      r_ovf <= (r_ovf & ~bus.clr_ovf) | w_setMask;
    end
  end

  assign bus.in_ready   = w_inReady;
  assign bus.out_valid  = r_outValid;
  assign bus.out_canal  = r_outCanal;
  assign bus.resultado  = r_resultado;
  assign bus.sat_pos    = r_satPos;
  assign bus.sat_neg    = r_satNeg;
  assign bus.ovf_sticky = r_ovf;

endmodule

// File: tb/tb_acumulador_sat.sv
// Bench for acumulador_sat: directed vector table, hand-written multi-cycle
// sequences and a randomized run scored against an arithmetic model.
module tb_acumulador_sat;

  localparam int ANCHO   = 16;
  localparam int CANALES = 4;
  localparam int CW      = $clog2(CANALES);
  localparam int MAXV    = (1 << (ANCHO-1)) - 1;
  localparam int MINV    = -(1 << (ANCHO-1));

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  acumulador_sat_if #(.ANCHO(ANCHO), .CANALES(CANALES)) bus();

  acumulador_sat #(.ANCHO(ANCHO), .CANALES(CANALES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int canal;
    int res;
    bit sp;
    bit sn;
  } exp_t;

  typedef struct {
    string name;
    int    ch;
    int    mode;
    int    op;
    int    res;
    bit    sp;
    bit    sn;
  } vec_t;

  exp_t               expQ[$];
  int                 mAcc[CANALES];
  bit [CANALES-1:0]   mSticky;
  int                 errors = 0;
  int                 checks = 0;

  bit                 lastAccepted;
  bit                 lastInReady;
  bit                 lastOutValid;
  integer             lastRes;

  vec_t               vecs[12];

  // Compare one observed value with its expected value.
  task automatic checkOutput(string name, integer actual, integer expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic integer resNow();
    integer r;
    r = $signed(bus.resultado);
    return r;
  endfunction

  // Reference behaviour: the new channel value from plain integer arithmetic.
  function automatic void modelAccept(int ch, int mode, int op);
    exp_t e;
    int   full;
    case (mode)
      0:       full = mAcc[ch] + op;
      1:       full = mAcc[ch] - op;
      2:       full = op;
      default: full = 0;
    endcase
    e.canal = ch;
    e.sp    = (full > MAXV);
    e.sn    = (full < MINV);
    e.res   = e.sp ? MAXV : (e.sn ? MINV : full);
    mAcc[ch] = e.res;
    if (e.sp || e.sn) mSticky[ch] = 1'b1;
    expQ.push_back(e);
  endfunction

  // Drive one cycle starting at a falling edge; score handshakes before the
  // rising edge and return at the next falling edge.
  task automatic applyStimulus(bit v, int ch, int mode, int op, bit oready,
                               bit [CANALES-1:0] clr);
    exp_t e;
    bus.in_valid  = v;
    bus.canal     = ch[CW-1:0];
    bus.modo      = mode[1:0];
    bus.operando  = op[ANCHO-1:0];
    bus.out_ready = oready;
    bus.clr_ovf   = clr;
    #1;
    lastInReady  = bus.in_ready;
    lastOutValid = bus.out_valid;
    lastRes      = resNow();
    lastAccepted = v && bus.in_ready;
    if (reset) begin
      if (bus.out_valid && oready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected output", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("sb out_canal", bus.out_canal, e.canal);
          checkOutput("sb resultado", resNow(), e.res);
          checkOutput("sb sat_pos", bus.sat_pos, e.sp);
          checkOutput("sb sat_neg", bus.sat_neg, e.sn);
        end
      end
      if (lastAccepted) modelAccept(ch, mode, op);
    end else begin
      checkOutput("in_ready during reset", bus.in_ready, 0);
      expQ.delete();
      for (int i = 0; i < CANALES; i++) mAcc[i] = 0;
      mSticky = '0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one isolated request and check its result against table constants.
  task automatic runVector(vec_t v);
    applyStimulus(1'b1, v.ch, v.mode, v.op, 1'b1, '0);
    checkOutput({v.name, " accepted"}, lastAccepted, 1);
    applyStimulus(1'b0, 0, 0, 0, 1'b1, '0);
    checkOutput({v.name, " out_valid"}, bus.out_valid, 1);
    checkOutput({v.name, " out_canal"}, bus.out_canal, v.ch);
    checkOutput({v.name, " resultado"}, resNow(), v.res);
    checkOutput({v.name, " sat_pos"}, bus.sat_pos, v.sp);
    checkOutput({v.name, " sat_neg"}, bus.sat_neg, v.sn);
    applyStimulus(1'b0, 0, 0, 0, 1'b1, '0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   nAcc;
    int   c;
    vec_t vx;

    vecs[0]  = '{"ld0 30000",    0, 2,  30000,  30000, 1'b0, 1'b0};
    vecs[1]  = '{"add0 2767",    0, 0,   2767,  32767, 1'b0, 1'b0};
    vecs[2]  = '{"add0 1 sat",   0, 0,      1,  32767, 1'b1, 1'b0};
    vecs[3]  = '{"ld1 min",      1, 2, -32768, -32768, 1'b0, 1'b0};
    vecs[4]  = '{"sub1 1 sat",   1, 1,      1, -32768, 1'b0, 1'b1};
    vecs[5]  = '{"ld1 0",        1, 2,      0,      0, 1'b0, 1'b0};
    vecs[6]  = '{"sub1 min sat", 1, 1, -32768,  32767, 1'b1, 1'b0};
    vecs[7]  = '{"ld3 -5",       3, 2,     -5,     -5, 1'b0, 1'b0};
    vecs[8]  = '{"add3 -10",     3, 0,    -10,    -15, 1'b0, 1'b0};
    vecs[9]  = '{"ld2 99",       2, 2,     99,     99, 1'b0, 1'b0};
    vecs[10] = '{"clr2",         2, 3,   1234,      0, 1'b0, 1'b0};
    vecs[11] = '{"add2 0",       2, 0,      0,      0, 1'b0, 1'b0};

    // Reset state
    reset = 1'b0;
    applyStimulus(1'b1, 1, 0, 3, 1'b1, '0);
    applyStimulus(1'b1, 1, 0, 3, 1'b1, '0);
    checkOutput("reset out_valid", bus.out_valid, 0);
    checkOutput("reset resultado", resNow(), 0);
    checkOutput("reset out_canal", bus.out_canal, 0);
    checkOutput("reset sat_pos", bus.sat_pos, 0);
    checkOutput("reset sat_neg", bus.sat_neg, 0);
    checkOutput("reset ovf_sticky", bus.ovf_sticky, 0);
    reset = 1'b1;
    applyStimulus(1'b0, 0, 0, 0, 1'b1, '0);
    checkOutput("idle out_valid", bus.out_valid, 0);

    // Directed vectors
    foreach (vecs[i]) runVector(vecs[i]);
    checkOutput("sticky after sats", bus.ovf_sticky, 4'b0011);

    // Back-to-back: ch2 add 5 four times with the consumer always ready
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i < 4, 2, 0, 5, 1'b1, '0);
      if (i < 4) checkOutput($sformatf("b2b in_ready %0d", i), lastInReady, 1);
      if (i >= 1 && i <= 4) begin
        checkOutput($sformatf("b2b out_valid %0d", i), bus.out_valid, 1);
        checkOutput($sformatf("b2b resultado %0d", i), resNow(), 5 * i);
      end else begin
        checkOutput($sformatf("b2b out_valid %0d", i), bus.out_valid, 0);
      end
    end

    // Backpressure: six adds of 1 on ch2 with the consumer stalled three cycles
    nAcc = 0;
    c = 0;
    while (c < 40 && (nAcc < 6 || expQ.size() != 0 || bus.out_valid)) begin
      applyStimulus(nAcc < 6, 2, 0, 1, !(c >= 3 && c <= 5), '0);
      if (lastAccepted) nAcc++;
      if (c >= 3 && c <= 5) begin
        checkOutput($sformatf("stall in_ready %0d", c), lastInReady, 0);
        checkOutput($sformatf("stall out_valid %0d", c), lastOutValid, 1);
        checkOutput($sformatf("stall resultado %0d", c), lastRes, 22);
      end
      c++;
    end
    checkOutput("stall accepted count", nAcc, 6);
    checkOutput("stall queue drained", expQ.size(), 0);
    checkOutput("stall out_valid end", bus.out_valid, 0);
    vx = '{"add2 0 after stall", 2, 0, 0, 26, 1'b0, 1'b0};
    runVector(vx);

    // Sticky: clear of bit 0 in the same edge as a new ch0 saturation
    applyStimulus(1'b1, 0, 0, 1, 1'b1, '0);
    checkOutput("sticky req accepted", lastAccepted, 1);
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 4'b0001);
    checkOutput("sticky sat_pos", bus.sat_pos, 1);
    checkOutput("sticky set wins", bus.ovf_sticky, 4'b0011);
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 4'b0001);
    checkOutput("sticky clear alone", bus.ovf_sticky, 4'b0010);
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 4'b1111);
    checkOutput("sticky clear all", bus.ovf_sticky, 0);
    mSticky = '0;

    // Randomized traffic scored against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, CANALES-1),
                    $urandom_range(0, 3), int'($urandom_range(0, 65535)) - 32768,
                    $urandom_range(0, 3) != 0, '0);
    end
    c = 0;
    while (c < 20 && (expQ.size() != 0 || bus.out_valid)) begin
      applyStimulus(1'b0, 0, 0, 0, 1'b1, '0);
      c++;
    end
    checkOutput("random queue drained", expQ.size(), 0);
    checkOutput("random out_valid end", bus.out_valid, 0);
    checkOutput("random ovf_sticky", bus.ovf_sticky, mSticky);

    // Reset with S1 and S2 both occupied
    applyStimulus(1'b1, 3, 0, 100, 1'b0, '0);
    applyStimulus(1'b1, 3, 0, 100, 1'b0, '0);
    checkOutput("pre-reset out_valid", bus.out_valid, 1);
    reset = 1'b0;
    applyStimulus(1'b1, 3, 0, 100, 1'b0, '0);
    reset = 1'b1;
    checkOutput("midreset out_valid", bus.out_valid, 0);
    checkOutput("midreset resultado", resNow(), 0);
    checkOutput("midreset out_canal", bus.out_canal, 0);
    checkOutput("midreset ovf_sticky", bus.ovf_sticky, 0);
    applyStimulus(1'b0, 0, 0, 0, 1'b1, '0);
    checkOutput("midreset no leftover", bus.out_valid, 0);
    vx = '{"post-reset add3 7", 3, 0, 7, 7, 1'b0, 1'b0};
    runVector(vx);
    for (int ch = 0; ch < 3; ch++) begin
      vx = '{$sformatf("post-reset add%0d 0", ch), ch, 0, 0, 0, 1'b0, 1'b0};
      runVector(vx);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acumulador_sat.md
ACUMULADOR_SAT -- requirements
Module: acumulador_sat

Interface
REQ-001 SHALL have parameter ANCHO, default 16, signed two's-complement data width (>=4).
REQ-002 SHALL have parameter CANALES, default 4, number of independent accumulators (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid&in_ready at an edge.
REQ-007 SHALL have port canal  input  log2(CANALES)  target accumulator.
REQ-008 SHALL have port modo  input  2  00 add, 01 subtract, 10 load, 11 clear.
REQ-009 SHALL have port operando  input  ANCHO  signed operand.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result when out_valid&out_ready at an edge.
REQ-012 SHALL have port out_canal  output  log2(CANALES)  channel of result.
REQ-013 SHALL have port resultado  output  ANCHO  signed new accumulator value.
REQ-014 SHALL have port sat_pos  output  1  result clamped to MAX (valid with out_valid).
REQ-015 SHALL have port sat_neg  output  1  result clamped to MIN (valid with out_valid).
REQ-016 SHALL have port ovf_sticky  output  CANALES  per-channel sticky saturation flag.
REQ-017 SHALL have port clr_ovf  input  CANALES  per-bit clear of ovf_sticky.

Function
REQ-018 SHALL define MAX = 2^(ANCHO-1)-1, MIN = -2^(ANCHO-1).
REQ-019 SHALL use two stages: S1 registers accepted request; S2 computes, writes acc[canal], loads output registers.
REQ-020 SHALL give latency 2: request accepted at edge k -> out_valid high after edge k+1 when not stalled.
REQ-021 SHALL compute add/sub at ANCHO+1 bits: add acc+op, sub acc-op (sub of MIN handled without wrap).
REQ-022 SHALL clamp: full-width result >MAX -> MAX with sat_pos=1; <MIN -> MIN with sat_neg=1; else exact, both flags 0.
REQ-023 SHALL for load write operando unchanged, for clear write 0; both with sat_pos=sat_neg=0.
REQ-024 SHALL write the S2 result into acc[canal] and present it on resultado in the same edge.
REQ-025 SHALL read acc at S2 compute time so back-to-back requests to one channel see the prior result (no hazard, no stale value).
REQ-026 SHALL stall when out_valid=1 and out_ready=0: output regs, S1 and acc hold; in_ready=0 if S1 occupied.
REQ-027 SHALL drive in_ready = !S1_valid | !out_valid | out_ready (combinational, full throughput when unstalled).
REQ-028 SHALL clear out_valid after out_ready handshake when S1 empty.
REQ-029 SHALL set ovf_sticky[c] when a saturated result for channel c is written; set wins over same-cycle clr_ovf[c].
REQ-030 SHALL ignore in_valid when in_ready=0; operando/canal/modo sampled only on acceptance.

Reset
REQ-031 SHALL on reset low at an edge: all acc=0, S1 empty, out_valid=0, resultado=0, out_canal=0, sat_pos=sat_neg=0, ovf_sticky=0.
REQ-032 SHALL discard in-flight S1/S2 requests on reset mid-operation; no out_valid until a new accepted request.
REQ-033 SHALL hold in_ready=0 while reset is low.

Verification (ANCHO=16, CANALES=4)
REQ-034 SHALL test add: load ch0=30000, add 2767 -> resultado 32767, flags 0; add 1 -> 32767, sat_pos=1, ovf_sticky[0]=1.
REQ-035 SHALL test sub: load ch1=-32768, sub 1 -> -32768, sat_neg=1; load ch1=0, sub -32768 -> 32767, sat_pos=1.
REQ-036 SHALL test back-to-back: ch2 add 5 every cycle x4, out_ready=1 -> results 5,10,15,20 on consecutive cycles, in_ready constant 1.
REQ-037 SHALL test backpressure: out_ready=0 for 3 cycles mid-stream -> resultado held, in_ready=0, no request lost or duplicated.
REQ-038 SHALL test sticky: set ovf_sticky[0], assert clr_ovf[0] same cycle as new ch0 saturation -> stays 1; clr_ovf[0] alone -> 0.
REQ-039 SHALL test reset mid-stream: reset low one edge with S1/S2 full -> out_valid=0, all acc 0; next add 7 on ch3 -> 7.
